// File: rtl/rv_multi_ctrl_fsm_if.sv
// Memory bus between the multicycle controller and instruction/data memory.
// Ports (via modports):
//   master (controller): MemReq, MemWrite, AdrSrc out; MemReady in
//   slave  (memory)    : MemReq, MemWrite, AdrSrc in;  MemReady out
// Handshake: MemReq acts as valid and MemReady as ready. An access completes
// in the cycle where both are high. The controller holds MemReq, MemWrite
// and AdrSrc stable until that cycle. MemReady while MemReq is low is ignored.
interface rv_multi_ctrl_fsm_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
  modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/rv_multi_ctrl_fsm.sv
// Main control FSM and ALU/immediate decoder for the multicycle RV32I core.
// Ports:
//   clk, reset (async, active-low)
//   op/funct3/funct7b5   instruction fields
//   Zero/Lt/LtU          ALU compare flags for branches
//   bus                  memory request/ready bus (master side)
//   IRWrite..ALUControl  datapath enables and mux selects
//   Trap/TrapCause       sticky halt indication (01 illegal, 10 timeout)
//   state_dbg            current FSM state encoding
module rv_multi_ctrl_fsm #(
  parameter int WAIT_MAX = 16,
  parameter int ALUC_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              Zero,
  input  logic              Lt,
  input  logic              LtU,
  rv_multi_ctrl_fsm_if.master bus,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic [2:0]        ImmSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              Trap,
  output logic [1:0]        TrapCause,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Count value at which the next unanswered wait cycle trips the timeout.
  localparam logic [CNT_W-1:0] WAIT_LIM = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       cause_q, cause_n;
  logic             illegal, taken, mem_state, timeout;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5, input logic rtype);
    case (f3)
      3'b000:  alu_dec = (rtype && b5) ? 4'h1 : 4'h0;
      3'b001:  alu_dec = 4'h7;
      3'b010:  alu_dec = 4'h5;
      3'b011:  alu_dec = 4'h6;
      3'b100:  alu_dec = 4'h4;
      3'b101:  alu_dec = b5 ? 4'h9 : 4'h8;
      3'b110:  alu_dec = 4'h3;
      default: alu_dec = 4'h2;
    endcase
  endfunction

  // Opcode/funct legality, evaluated while in DECODE.
  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_LOAD:  illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE: illegal = funct3[2] || (funct3 == 3'b011);
      OP_R:     illegal = funct7b5 && !((funct3 == 3'b000) || (funct3 == 3'b101));
      OP_I:     illegal = funct7b5 && (funct3 == 3'b001);
      OP_BR:    illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_JALR:  illegal = (funct3 != 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: illegal = 1'b0;
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = LtU;
      3'b111:  taken = !LtU;
      default: taken = 1'b0;
    endcase
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = (WAIT_MAX > 0) && mem_state && !bus.MemReady && (cnt == WAIT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      cnt     <= '0;
      cause_q <= 2'b00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cause_q <= cause_n;
    end
  end

  // Next state, wait counter and trap cause.
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    case (state)
      S_FETCH:  if (bus.MemReady) state_n = S_DECODE;
      S_DECODE: begin
        if (illegal) begin
          state_n = S_TRAP;
          cause_n = 2'b01;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_n = S_MEMADR;
            OP_R:              state_n = S_EXECR;
            OP_I:              state_n = S_EXECI;
            OP_BR:             state_n = S_BRANCH;
            OP_JAL:            state_n = S_JAL;
            OP_JALR:           state_n = S_JALR;
            OP_LUI:            state_n = S_LUI;
            default:           state_n = S_AUIPC;
          endcase
        end
      end
      S_MEMADR: state_n = op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.MemReady) state_n = S_MEMWB;
      S_MEMWR:  if (bus.MemReady) state_n = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_n = S_ALUWB;
      S_JALR:   state_n = S_JALWB;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_FETCH;
    endcase
    if (timeout) begin
      state_n = S_TRAP;
      cause_n = 2'b10;
    end

    cnt_n = cnt;
    if (state_n != state) cnt_n = '0;
    else if (mem_state && !bus.MemReady && (cnt != '1)) cnt_n = cnt + 1'b1;
  end

  // Datapath controls. Every output is held at 0 while reset is asserted so
  // that an access in flight is dropped in the same cycle.
  always_comb begin
    bus.MemReq   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.AdrSrc   = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ImmSrc       = 3'b000;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = '0;
    Trap         = 1'b0;
    TrapCause    = cause_q;
    case (state)
      S_FETCH: begin
        bus.MemReq = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = bus.MemReady;
        PCWrite    = bus.MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        // JAL's target is formed here too, so it needs the J immediate.
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b001 : 3'b000;
      end
      S_MEMRD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALUC_W'(alu_dec(funct3, funct7b5, 1'b1));
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = ALUC_W'(alu_dec(funct3, funct7b5, 1'b0));
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALUC_W'(4'h1);
        PCWrite    = taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JALWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        ALUControl = ALUC_W'(4'hA);
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
      end
      default: Trap = 1'b1;
    endcase
    if (!reset) begin
      bus.MemReq   = 1'b0;
      bus.MemWrite = 1'b0;
      bus.AdrSrc   = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ImmSrc       = 3'b000;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ResultSrc    = 2'b00;
      ALUControl   = '0;
      Trap         = 1'b0;
      TrapCause    = 2'b00;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rv_multi_ctrl_fsm.sv
module tb_rv_multi_ctrl_fsm;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4;
  localparam int ST_MEMWR = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9;
  localparam int ST_JAL = 10, ST_JALR = 11, ST_JALWB = 12, ST_LUI = 13, ST_TRAP = 15;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0, Lt = 1'b0, LtU = 1'b0;
  logic       IRWrite, PCWrite, RegWrite, Trap;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, TrapCause;
  logic [3:0] ALUControl, state_dbg;

  rv_multi_ctrl_fsm_if bus ();

  rv_multi_ctrl_fsm #(.WAIT_MAX(4), .ALUC_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .LtU(LtU), .bus(bus),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .Trap(Trap), .TrapCause(TrapCause), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // From FETCH: fetch completes at once, decode, land in the first execute state.
  task automatic into_exec(input logic [6:0] o, input logic [2:0] f3, input logic b5);
    op = o;
    funct3 = f3;
    funct7b5 = b5;
    bus.MemReady = 1'b1;
    cyc();
    cyc();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_memreq", 32'(bus.MemReq), 0);
    check("rst_trap", 32'(Trap), 0);
    cyc();
    reset = 1'b1;
    #1;
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic z,
                        input logic lt, input logic ltu, input logic exp_pc);
    Zero = z;
    Lt = lt;
    LtU = ltu;
    into_exec(OP_BR, f3, 1'b0);
    check({tag, "_state"}, 32'(state_dbg), ST_BRANCH);
    check({tag, "_aluc"}, 32'(ALUControl), 1);
    check({tag, "_pcwrite"}, 32'(PCWrite), 32'(exp_pc));
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemReady = 1'b1;
    #1;
    check("reset_state", 32'(state_dbg), ST_FETCH);
    check("reset_memreq", 32'(bus.MemReq), 0);
    check("reset_irwrite", 32'(IRWrite), 0);
    check("reset_alusrcb", 32'(ALUSrcB), 0);
    @(posedge clk);
    cyc();
    reset = 1'b1;
    #1;

    // fetch with immediate ready, then lw with 3 wait states
    check("fetch_state", 32'(state_dbg), ST_FETCH);
    check("fetch_memreq", 32'(bus.MemReq), 1);
    check("fetch_irwrite", 32'(IRWrite), 1);
    check("fetch_pcwrite", 32'(PCWrite), 1);
    check("fetch_alusrcb", 32'(ALUSrcB), 2);
    check("fetch_resultsrc", 32'(ResultSrc), 2);
    op = OP_LOAD;
    funct3 = 3'b010;
    cyc(); #1;
    check("dec_state", 32'(state_dbg), ST_DECODE);
    check("dec_irwrite", 32'(IRWrite), 0);
    check("dec_pcwrite", 32'(PCWrite), 0);
    check("dec_alusrca", 32'(ALUSrcA), 1);
    check("dec_immsrc", 32'(ImmSrc), 2);
    cyc(); #1;
    check("lw_adr_state", 32'(state_dbg), ST_MEMADR);
    check("lw_adr_alusrca", 32'(ALUSrcA), 2);
    check("lw_adr_immsrc", 32'(ImmSrc), 0);
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("lw_wait_state", 32'(state_dbg), ST_MEMRD);
      check("lw_wait_memreq", 32'(bus.MemReq), 1);
      check("lw_wait_adrsrc", 32'(bus.AdrSrc), 1);
    end
    cyc();
    bus.MemReady = 1'b1;
    #1;
    check("lw_rdy_state", 32'(state_dbg), ST_MEMRD);
    check("lw_rdy_memreq", 32'(bus.MemReq), 1);
    cyc(); #1;
    check("lw_wb_state", 32'(state_dbg), ST_MEMWB);
    check("lw_wb_regwrite", 32'(RegWrite), 1);
    check("lw_wb_resultsrc", 32'(ResultSrc), 1);
    check("lw_wb_memreq", 32'(bus.MemReq), 0);
    cyc(); #1;
    check("lw_done_state", 32'(state_dbg), ST_FETCH);
    check("lw_done_regwrite", 32'(RegWrite), 0);

    // ALU ops
    into_exec(OP_R, 3'b000, 1'b1);
    check("sub_state", 32'(state_dbg), ST_EXECR);
    check("sub_aluc", 32'(ALUControl), 1);
    check("sub_alusrca", 32'(ALUSrcA), 2);
    check("sub_alusrcb", 32'(ALUSrcB), 0);
    cyc(); #1;
    check("sub_wb_state", 32'(state_dbg), ST_ALUWB);
    check("sub_wb_regwrite", 32'(RegWrite), 1);
    check("sub_wb_resultsrc", 32'(ResultSrc), 0);
    cyc();
    into_exec(OP_I, 3'b000, 1'b1);
    check("addi_state", 32'(state_dbg), ST_EXECI);
    check("addi_aluc", 32'(ALUControl), 0);
    check("addi_alusrcb", 32'(ALUSrcB), 1);
    cyc(); cyc();
    into_exec(OP_I, 3'b101, 1'b1);
    check("srai_aluc", 32'(ALUControl), 9);
    cyc(); cyc();
    into_exec(OP_R, 3'b101, 1'b0);
    check("srl_aluc", 32'(ALUControl), 8);
    cyc(); cyc();
    into_exec(OP_R, 3'b011, 1'b0);
    check("sltu_aluc", 32'(ALUControl), 6);
    cyc(); cyc();
    into_exec(OP_LUI, 3'b000, 1'b0);
    check("lui_state", 32'(state_dbg), ST_LUI);
    check("lui_aluc", 32'(ALUControl), 10);
    check("lui_immsrc", 32'(ImmSrc), 4);
    cyc(); cyc();

    // jumps
    op = OP_JAL;
    cyc(); #1;
    check("jal_dec_immsrc", 32'(ImmSrc), 3);
    cyc(); #1;
    check("jal_state", 32'(state_dbg), ST_JAL);
    check("jal_pcwrite", 32'(PCWrite), 1);
    check("jal_alusrcb", 32'(ALUSrcB), 2);
    cyc(); #1;
    check("jal_wb_regwrite", 32'(RegWrite), 1);
    cyc();
    into_exec(OP_JALR, 3'b000, 1'b0);
    check("jalr_state", 32'(state_dbg), ST_JALR);
    check("jalr_alusrca", 32'(ALUSrcA), 2);
    cyc(); #1;
    check("jalwb_state", 32'(state_dbg), ST_JALWB);
    check("jalwb_regwrite", 32'(RegWrite), 1);
    check("jalwb_pcwrite", 32'(PCWrite), 1);
    check("jalwb_resultsrc", 32'(ResultSrc), 2);
    cyc();

    // branches
    branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    branch("bgeu_ltu1", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    branch("bgeu_ltu0", 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    branch("blt_lt1", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("br_back_state", 32'(state_dbg), ST_FETCH);

    // illegal opcode trap, sticky through memory noise
    into_exec(7'b0000000, 3'b000, 1'b0);
    check("ill_state", 32'(state_dbg), ST_TRAP);
    check("ill_trap", 32'(Trap), 1);
    check("ill_cause", 32'(TrapCause), 1);
    for (int i = 0; i < 10; i++) begin
      bus.MemReady = i[0];
      cyc(); #1;
      check("ill_hold_state", 32'(state_dbg), ST_TRAP);
      check("ill_hold_memreq", 32'(bus.MemReq), 0);
    end
    do_reset();
    check("ill_clr_state", 32'(state_dbg), ST_FETCH);
    check("ill_clr_cause", 32'(TrapCause), 0);

    // illegal branch funct3
    into_exec(OP_BR, 3'b010, 1'b0);
    check("illbr_state", 32'(state_dbg), ST_TRAP);
    check("illbr_cause", 32'(TrapCause), 1);
    do_reset();

    // sw timeout after 4 wait cycles
    into_exec(OP_STORE, 3'b010, 1'b0);
    check("sw_adr_immsrc", 32'(ImmSrc), 1);
    bus.MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("sw_wait_state", 32'(state_dbg), ST_MEMWR);
      check("sw_wait_memwrite", 32'(bus.MemWrite), 1);
    end
    cyc(); #1;
    check("tmo_state", 32'(state_dbg), ST_TRAP);
    check("tmo_trap", 32'(Trap), 1);
    check("tmo_cause", 32'(TrapCause), 2);
    check("tmo_memwrite", 32'(bus.MemWrite), 0);
    check("tmo_memreq", 32'(bus.MemReq), 0);
    do_reset();

    // reset during a store wait
    into_exec(OP_STORE, 3'b000, 1'b0);
    bus.MemReady = 1'b0;
    cyc(); cyc();
    #1;
    check("swr_pre_memreq", 32'(bus.MemReq), 1);
    reset = 1'b0;
    #1;
    check("swr_memreq", 32'(bus.MemReq), 0);
    check("swr_memwrite", 32'(bus.MemWrite), 0);
    check("swr_adrsrc", 32'(bus.AdrSrc), 0);
    check("swr_state", 32'(state_dbg), ST_FETCH);
    cyc();
    reset = 1'b1;
    #1;
    check("swr_rel_state", 32'(state_dbg), ST_FETCH);
    check("swr_rel_trap", 32'(Trap), 0);
    check("swr_rel_memreq", 32'(bus.MemReq), 1);
    check("swr_rel_irwrite", 32'(IRWrite), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
